mem_stage_lsu: RTL
==================

# mem_stage_lsu

Memory-stage load/store unit between the EX/MEM pipeline register and the MEM/WB pipeline register of the RV32I pipeline. It turns the M-stage ALU address, store data and funct3 into a single-outstanding request on the data-memory bus. It also generates byte enables and lane-replicated store data, and returns the raw 32-bit load word as `ReadData`. While a bus transaction is incomplete it asserts `StallM` to freeze PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
- `TIMEOUT`, 255: maximum wait cycles in REQ or WAIT_RD before the access is aborted; 0 disables the timeout.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `ALUResultM` input 32: byte address of the access.
- `WriteDataM` input 32: store data; the value is in the low bits.
- `MemReadM` input 1: the M-stage instruction is a load.
- `MemWriteM` input 1: the M-stage instruction is a store. `MemReadM` and `MemWriteM` are never both 1.
- `funct3M` input 3: access size and sign (000 b, 001 h, 010 w, 100 bu, 101 hu).
- `dmem_req` output 1: request valid.
- `dmem_we` output 1: 1 means write.
- `dmem_addr` output 32: word-aligned address, `{ALUResultM[31:2],2'b00}`.
- `dmem_be` output 4: byte enables.
- `dmem_wdata` output 32: lane-replicated store data.
- `dmem_gnt` input 1: request accepted in this cycle.
- `dmem_rvalid` input 1: read data valid; arrives at least 1 cycle after gnt.
- `dmem_rdata` input 32: read data.
- `ReadData` output 32: raw load word, consumed by the MEM/WB register.
- `StallM` output 1: freeze the pipeline.
- `MisalignM` output 1: one-cycle flag for a misaligned access; no bus request is made.
- `BusErrM` output 1: one-cycle flag for an access aborted by timeout.
- `StallCount` output 32: saturating count of cycles with `StallM`=1.

## Operation
- Access types:
  - `op` = `MemReadM|MemWriteM`.
  - `mis` = (size w and `ALUResultM[1:0]`≠0) or (size h/hu and `ALUResultM[0]`≠0).
- Store lanes:
  - Byte: `dmem_wdata={4{WriteDataM[7:0]}}`, `dmem_be=4'b0001<<ALUResultM[1:0]`.
  - Half: `dmem_wdata={2{WriteDataM[15:0]}}`, `dmem_be=4'b0011<<ALUResultM[1:0]`.
  - Word: `dmem_wdata=WriteDataM`, `dmem_be=4'hF`.
  - Loads drive `dmem_be=4'hF`.
- FSM states: IDLE, REQ, WAIT_RD.
  - IDLE:
    - `dmem_req = op & ~mis`.
    - If gnt arrives with a store, the store is complete: stay in IDLE, no stall.
    - If gnt arrives with a load, go to WAIT_RD.
    - If there is no gnt, go to REQ.
  - REQ: hold `dmem_req`=1 with the same address, be, wdata and we; the inputs are frozen by `StallM`. On gnt, a store goes to IDLE and a load goes to WAIT_RD.
  - WAIT_RD: `dmem_req`=0. On rvalid, go to IDLE.
- `StallM` is combinational:
  - It is 1 in IDLE when `op & ~mis` and the access is not completing this cycle. A store completes on gnt; a load never completes in IDLE.
  - It is 1 in REQ unless a store gets gnt this cycle.
  - It is 1 in WAIT_RD unless rvalid is high this cycle.
- `ReadData` equals `dmem_rdata` when in WAIT_RD with rvalid; otherwise it is 0. MEM/WB captures it on the edge where `StallM` falls.
- Misaligned access: no request, `StallM`=0, `ReadData`=0, `MisalignM`=1 for that cycle. The M stage advances normally.
- Timeout:
  - An 8+ bit wait counter clears on entry to REQ/WAIT_RD and increments each cycle spent there.
  - When it reaches `TIMEOUT` (with `TIMEOUT`≠0), the FSM goes to IDLE. `StallM`=0 and `BusErrM`=1 in that cycle, and `ReadData`=0.
  - An rvalid that arrives later in IDLE is ignored.
- `StallCount` increments on every cycle with `StallM`=1 and saturates at `32'hFFFF_FFFF`.

## Timing
- Reset values: state IDLE, wait counter 0, `StallCount`=0, `BusErrM`=0. `dmem_req`=0 while `rst`=1, regardless of inputs.
- Reset mid-transaction: the FSM returns to IDLE on the next edge, and `StallM`, `dmem_req` and `BusErrM` are all 0 in the reset cycle. A pending rvalid or gnt after reset is ignored unless a new request is active.
- Latency:
  - Store with immediate gnt: 0 stall cycles.
  - Store granted after N wait cycles: N stall cycles.
  - Load with gnt at cycle 0 and rvalid at cycle k: k stall cycles, with data released in cycle k.
- Only one outstanding transaction; `dmem_req` is never asserted in WAIT_RD.
- gnt in the same cycle as a timeout: the grant wins and the timeout is not flagged.

## Test plan
- sw to 0x100, `WriteDataM`=0xDEADBEEF, gnt held high → one cycle with `dmem_req`=1, `dmem_be`=F, `dmem_wdata`=DEADBEEF, `StallM`=0.
- sb to 0x103 with data 0x5A, gnt delayed 3 cycles → `dmem_be`=4'b1000, `dmem_wdata`=5A5A5A5A, `StallM`=1 for exactly 3 cycles, then IDLE; `StallCount`=3.
- lw from 0x200, gnt immediate, rvalid 2 cycles later with 0x12345678 → `StallM` high for 2 cycles; `ReadData`=0x12345678 in the rvalid cycle, 0 otherwise.
- lh from 0x201 → no `dmem_req`, `MisalignM`=1 for 1 cycle, `StallM`=0.
- `TIMEOUT`=4, lw granted but rvalid never arrives → `BusErrM`=1 in the 4th wait cycle, `StallM` drops, FSM returns to IDLE; a late rvalid has no effect.
- `rst` asserted while in WAIT_RD → next cycle IDLE, `StallM`=0, `StallCount`=0.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: a single-outstanding data-memory bus master with
// lane steering, misalignment detection, a wait timeout and a stall-cycle counter.
module mem_stage_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ReadData,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic [31:0] StallCount
);

  localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    WAIT_RD = 2'b10
  } state_t;

  state_t        state_r;
  state_t        nextState_s;
  logic [CW-1:0] waitCnt_r;
  logic [31:0]   stallCount_r;
  logic          op_s;
  logic          mis_s;
  logic          access_s;
  logic          timeout_s;
  logic          req_s;
  logic          stall_s;
  logic          busErr_s;
  logic          misalign_s;
  logic [31:0]   readData_s;

  function automatic logic [3:0] laneEnable(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << offset;
      2'b01:   be = 4'b0011 << offset;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] laneData(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{data[7:0]}};
      2'b01:   d = {2{data[15:0]}};
      default: d = data;
    endcase
    return d;
  endfunction

  assign op_s      = MemReadM | MemWriteM;
  assign mis_s     = ((funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00)) ||
                     ((funct3M[1:0] == 2'b01) && ALUResultM[0]);
  assign access_s  = op_s & ~mis_s;
  // The counter value in the k-th wait cycle is k-1, so the abort lands in wait cycle TIMEOUT.
  assign timeout_s = TO_EN && (waitCnt_r == TO_LAST);

  // Next-state and bus/pipeline control decode.
  always_comb begin
    nextState_s = state_r;
    req_s       = 1'b0;
    stall_s     = 1'b0;
    busErr_s    = 1'b0;
    misalign_s  = 1'b0;
    readData_s  = 32'h0000_0000;
    if (rst) begin
      nextState_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (access_s) begin
            req_s = 1'b1;
            if (dmem_gnt) begin
              nextState_s = MemWriteM ? IDLE : WAIT_RD;
              stall_s     = ~MemWriteM;
            end else begin
              nextState_s = REQ;
              stall_s     = 1'b1;
            end
          end else begin
            misalign_s = op_s & mis_s;
          end
        end
        REQ: begin
          req_s = 1'b1;
          if (dmem_gnt) begin
            nextState_s = MemWriteM ? IDLE : WAIT_RD;
            stall_s     = ~MemWriteM;
          end else if (timeout_s) begin
            nextState_s = IDLE;
            busErr_s    = 1'b1;
          end else begin
            stall_s = 1'b1;
          end
        end
        WAIT_RD: begin
          if (dmem_rvalid) begin
            nextState_s = IDLE;
            readData_s  = dmem_rdata;
          end else if (timeout_s) begin
            nextState_s = IDLE;
            busErr_s    = 1'b1;
          end else begin
            stall_s = 1'b1;
          end
        end
        default: begin
          nextState_s = IDLE;
        end
      endcase
    end
  end

  // State, wait counter and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      waitCnt_r    <= '0;
      stallCount_r <= 32'h0000_0000;
    end else begin
      state_r <= nextState_s;
      if (nextState_s != state_r) begin
        waitCnt_r <= '0;
      end else if (waitCnt_r != {CW{1'b1}}) begin
        waitCnt_r <= waitCnt_r + CW'(1);
      end else begin
        waitCnt_r <= waitCnt_r;
      end
      if (stall_s && (stallCount_r != 32'hFFFF_FFFF)) begin
        stallCount_r <= stallCount_r + 32'd1;
      end else begin
        stallCount_r <= stallCount_r;
      end
    end
  end

  // Address/lanes come straight from the M stage; StallM holds them steady while in REQ.
  assign dmem_req   = req_s;
  assign dmem_we    = req_s & MemWriteM;
  assign dmem_addr  = {ALUResultM[31:2], 2'b00};
  assign dmem_be    = MemWriteM ? laneEnable(funct3M[1:0], ALUResultM[1:0]) : 4'b1111;
  assign dmem_wdata = laneData(funct3M[1:0], WriteDataM);
  assign ReadData   = readData_s;
  assign StallM     = stall_s;
  assign MisalignM  = misalign_s;
  assign BusErrM    = busErr_s;
  assign StallCount = stallCount_r;

endmodule
